// File: rtl/aes_tb_pkg.sv
// rtl/aes_tb_pkg.sv - shared constants and FSM state type for the AES result collector
//
// Purpose: widths, core latency and MISR taps used by the AES stimulus bench
//          blocks, plus the collector's state encoding.
package aes_tb_pkg;

  localparam int AES_WIDTH   = 128;
  localparam int AES_LATENCY = 21;
  localparam logic [127:0] MISR_POLY_128 = 128'h87;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } fsm_state_t;

endpackage

// File: rtl/aes_out_collector_misr.sv
// rtl/aes_out_collector_misr.sv - multiple-input signature register
//
// Purpose: Galois-style MISR; each enabled edge shifts left, folds the
//          feedback taps in when the msb falls out, and xors the data word in.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (loads seed)
//   clear  in   synchronous reload of seed; wins over en
//   seed   in   WIDTH  value loaded on reset/clear
//   en     in   absorb data on this edge
//   data   in   WIDTH  word to fold in
//   sig    out  WIDTH  current signature
module misr #(
  parameter int WIDTH = 128,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(128'h87)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] next_sig;

  always_comb begin
    next_sig = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= seed;
    end else if (clear) begin
      sig <= seed;
    end else if (en) begin
      sig <= next_sig;
    end
  end

endmodule

// File: rtl/aes_out_collector.sv
// rtl/aes_out_collector.sv - AES-128 result collector with valid pipeline and MISR
//
// Purpose: delays the issue strobe by LATENCY edges to know when ct is valid,
//          folds each valid word into a MISR, counts results and flags done.
// Ports:
//   clk           in   clock shared with aes_128
//   rst_n         in   asynchronous active-low reset
//   start         in   one-cycle pulse: clear and begin a run
//   num_expected  in   32     results in the run, sampled on start
//   in_valid      in   aes_128 samples a new input on this edge
//   ct            in   WIDTH  aes_128 output
//   signature     out  WIDTH  MISR contents
//   result_count  out  32     results absorbed
//   busy          out  high in RUN or DRAIN
//   done          out  high in DONE
//   overflow      out  sticky: in_valid seen after all words were issued
module aes_out_collector
  import aes_tb_pkg::*;
#(
  parameter int WIDTH   = AES_WIDTH,
  parameter int LATENCY = AES_LATENCY,
  parameter logic [WIDTH-1:0] MISR_SEED = '0,
  parameter logic [WIDTH-1:0] MISR_POLY = WIDTH'(MISR_POLY_128)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      num_expected,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ct,
  output logic [WIDTH-1:0] signature,
  output logic [31:0]      result_count,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  fsm_state_t         state;
  logic [31:0]        exp_count;
  logic [31:0]        issued;
  logic [LATENCY-1:0] vld_pipe;

  logic in_flight;
  logic accept;
  logic capture;

  always_comb begin
    in_flight = (state == RUN) || (state == DRAIN);
    accept    = (state == RUN) && in_valid && (issued < exp_count);
    capture   = in_flight && vld_pipe[LATENCY-1];
  end

  misr #(
    .WIDTH (WIDTH),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start),
    .seed  (MISR_SEED),
    .en    (capture),
    .data  (ct),
    .sig   (signature)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      exp_count    <= '0;
      issued       <= '0;
      vld_pipe     <= '0;
      result_count <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
    end else if (start) begin
      exp_count    <= num_expected;
      issued       <= '0;
      vld_pipe     <= '0;
      result_count <= '0;
      overflow     <= 1'b0;
      if (num_expected == 32'd0) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        state <= RUN;
        busy  <= 1'b1;
        done  <= 1'b0;
      end
    end else if (in_flight) begin
      vld_pipe <= (vld_pipe << 1) | LATENCY'(accept);

      if (accept) begin
        issued <= issued + 32'd1;
        if (issued + 32'd1 == exp_count) begin
          state <= DRAIN;
        end
      end

      // RUN hands over to DRAIN as soon as the last word is issued, so any
      // further strobe while words are still in flight lands in DRAIN; it is
      // an excess issue either way and must be flagged.
      if (in_valid && (issued == exp_count)) begin
        overflow <= 1'b1;
      end

      // Completion overrides the RUN->DRAIN move above; the two cannot
      // coincide anyway since completion implies every word was issued.
      if (capture) begin
        result_count <= result_count + 32'd1;
        if (result_count + 32'd1 == exp_count) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule
